// File: rtl/alu_control_pkg.sv
// ============================================================================
// Module      : alu_control_pkg
// Description : Shared ALU op, alu_op class and branch funct3 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_control_pkg;

  // ALU operation codes (low three bits of the ALU function select)
  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SLT     = 3'b010;
  localparam logic [2:0] ALU_SLTU    = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SHIFTR  = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;

  // ALU class coming from the main control unit
  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_ARITH  = 2'b10;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b11;

  // Branch funct3 encodings
  localparam logic [2:0] BRANCH_EQ  = 3'b000;
  localparam logic [2:0] BRANCH_NE  = 3'b001;
  localparam logic [2:0] BRANCH_LT  = 3'b100;
  localparam logic [2:0] BRANCH_GE  = 3'b101;
  localparam logic [2:0] BRANCH_LTU = 3'b110;
  localparam logic [2:0] BRANCH_GEU = 3'b111;

endpackage : alu_control_pkg

`default_nettype wire

// File: rtl/alu_control_branch_funct_map.sv
// ============================================================================
// Module      : alu_control_branch_funct_map
// Description : Maps branch funct3 to the ALU compare op and a reserved flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control_branch_funct_map
  import alu_control_pkg::*;
(
  input  logic [2:0] funct3,
  output logic [2:0] bop,
  output logic       rsvd
);

  always_comb begin
    bop  = ALU_ADD_SUB;
    rsvd = 1'b0;
    case (funct3)
      BRANCH_EQ,  BRANCH_NE:  bop = ALU_ADD_SUB;
      BRANCH_LT,  BRANCH_GE:  bop = ALU_SLT;
      BRANCH_LTU, BRANCH_GEU: bop = ALU_SLTU;
      default: begin
        // 010 / 011 are unused branch encodings: fall back to a subtract
        bop  = ALU_ADD_SUB;
        rsvd = 1'b1;
      end
    endcase
  end

endmodule : alu_control_branch_funct_map

`default_nettype wire

// File: rtl/alu_control.sv
// ============================================================================
// Module      : alu_control
// Description : Decodes alu_op / funct3 / bit30 into the 4-bit ALU select,
//               with a combinational and a registered copy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control
  import alu_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] alu_op,
  input  logic [2:0] inst_funct3,
  input  logic       inst_bit30,
  output logic [3:0] alu_funct,
  output logic [3:0] alu_funct_q,
  output logic       branch_rsvd
);

  logic [2:0] w_bop;
  logic       w_rsvd;
  logic       w_mod;
  logic [3:0] r_alu_funct_q;

  alu_control_branch_funct_map u_branch_map (
    .funct3 (inst_funct3),
    .bop    (w_bop),
    .rsvd   (w_rsvd)
  );

  // bit30 only modifies ADD/SUB and SRL/SRA; elsewhere it is an immediate bit
  assign w_mod = inst_bit30 &
                 ((inst_funct3 == ALU_ADD_SUB) | (inst_funct3 == ALU_SHIFTR));

  always_comb begin
    alu_funct   = {1'b0, ALU_ADD_SUB};
    branch_rsvd = 1'b0;
    case (alu_op)
      ALU_OP_MEM:    alu_funct = {1'b0, ALU_ADD_SUB};
      ALU_OP_SUB:    alu_funct = {1'b1, ALU_ADD_SUB};
      ALU_OP_ARITH:  alu_funct = {w_mod, inst_funct3};
      ALU_OP_BRANCH: begin
        alu_funct   = {1'b1, w_bop};
        branch_rsvd = w_rsvd;
      end
      default: begin
        alu_funct   = {1'b0, ALU_ADD_SUB};
        branch_rsvd = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_funct_q <= 4'b0000;
    end else begin
      r_alu_funct_q <= alu_funct;
    end
  end

  assign alu_funct_q = r_alu_funct_q;

endmodule : alu_control

`default_nettype wire

// File: tb/tb_alu_control.sv
// ============================================================================
// Module      : tb_alu_control
// Description : Directed and exhaustive checks of the ALU control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_control;
  import alu_control_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [1:0] alu_op;
  logic [2:0] inst_funct3;
  logic       inst_bit30;
  logic [3:0] alu_funct;
  logic [3:0] alu_funct_q;
  logic       branch_rsvd;

  int errors = 0;
  int checks = 0;

  alu_control dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alu_op      (alu_op),
    .inst_funct3 (inst_funct3),
    .inst_bit30  (inst_bit30),
    .alu_funct   (alu_funct),
    .alu_funct_q (alu_funct_q),
    .branch_rsvd (branch_rsvd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [1:0] op, input logic [2:0] f3, input logic b30);
    alu_op      = op;
    inst_funct3 = f3;
    inst_bit30  = b30;
    #20;
  endtask

  // Reference decode written from the rule table, not from the RTL structure
  function automatic logic [3:0] ref_funct(input logic [1:0] op, input logic [2:0] f3,
                                           input logic b30);
    logic [3:0] r;
    if (op == 2'b00)      r = 4'b0000;
    else if (op == 2'b01) r = 4'b1000;
    else if (op == 2'b10) r = {b30 & (f3 == 3'b000 || f3 == 3'b101), f3};
    else                  r = f3[2] ? {2'b10, 1'b1, f3[1]} : 4'b1000;
    return r;
  endfunction

  function automatic logic ref_rsvd(input logic [1:0] op, input logic [2:0] f3);
    return (op == 2'b11) && (f3[2:1] == 2'b01);
  endfunction

  initial begin
    reset_n     = 1'b1;
    alu_op      = 2'b00;
    inst_funct3 = 3'b000;
    inst_bit30  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_q", alu_funct_q, 4'b0000);

    // Exhaustive sweep of {alu_op, funct3, bit30}
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = i[5:0];
      apply(v[5:4], v[3:1], v[0]);
      check($sformatf("sweep_funct[%0d]", i), alu_funct, ref_funct(v[5:4], v[3:1], v[0]));
      check($sformatf("sweep_rsvd[%0d]", i), {3'b000, branch_rsvd},
            {3'b000, ref_rsvd(v[5:4], v[3:1])});
    end

    // Directed vectors with hand-computed results
    apply(2'b00, 3'b111, 1'b1); check("mem_add",   alu_funct, 4'b0000);
    apply(2'b01, 3'b111, 1'b1); check("force_sub", alu_funct, 4'b1000);
    apply(2'b10, 3'b000, 1'b0); check("r_add",     alu_funct, 4'b0000);
    apply(2'b10, 3'b000, 1'b1); check("r_sub",     alu_funct, 4'b1000);
    apply(2'b10, 3'b101, 1'b0); check("r_srl",     alu_funct, 4'b0101);
    apply(2'b10, 3'b101, 1'b1); check("r_sra",     alu_funct, 4'b1101);
    apply(2'b10, 3'b111, 1'b1); check("r_and_b30", alu_funct, 4'b0111);
    apply(2'b10, 3'b001, 1'b1); check("r_sll_b30", alu_funct, 4'b0001);
    apply(2'b11, 3'b001, 1'b0); check("br_bne",    alu_funct, 4'b1000);
    check("br_bne_rsvd", {3'b000, branch_rsvd}, 4'b0000);
    apply(2'b11, 3'b101, 1'b0); check("br_bge",    alu_funct, 4'b1010);
    apply(2'b11, 3'b110, 1'b0); check("br_bltu",   alu_funct, 4'b1011);
    apply(2'b11, 3'b011, 1'b0); check("br_rsvd_f", alu_funct, 4'b1000);
    check("br_rsvd_flag", {3'b000, branch_rsvd}, 4'b0001);
    check("q_held_in_reset", alu_funct_q, 4'b0000);

    // Registered path: release, load, async clear, sync release
    @(negedge clk);
    reset_n = 1'b1;
    alu_op = 2'b10; inst_funct3 = 3'b110; inst_bit30 = 1'b0;
    #1 check("q_release_no_edge", alu_funct_q, 4'b0000);
    @(posedge clk); #1 check("q_load", alu_funct_q, 4'b0110);
    #1 reset_n = 1'b0;
    #1 check("q_async_clear", alu_funct_q, 4'b0000);
    check("comb_during_reset", alu_funct, 4'b0110);
    @(posedge clk); #1 check("q_hold_low", alu_funct_q, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("q_after_release", alu_funct_q, 4'b0000);
    @(posedge clk); #1 check("q_first_edge", alu_funct_q, 4'b0110);
    alu_op = 2'b01;
    @(posedge clk); #1 check("q_track", alu_funct_q, 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_control

`default_nettype wire
